// File: rtl/ascon_ctrl_pkg.sv
// ASCON controller shared types and constants.
// State encoding, command modes, rates and timing.
package ascon_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_AD,
    S_PAY,
    S_FINAL,
    S_SQZ,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_ENC  = 2'd0;
  localparam logic [1:0] MODE_DEC  = 2'd1;
  localparam logic [1:0] MODE_HASH = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam logic [4:0] RATE_AEAD = 5'd16;
  localparam logic [4:0] RATE_HASH = 5'd8;

  localparam int SQZ_SLOTS  = 4;
  localparam int BLK_CYCLES = 2;

  localparam logic [1:0] LAST_CYC  = 2'(BLK_CYCLES - 1);
  localparam logic [1:0] LAST_SLOT = 2'(SQZ_SLOTS - 1);

endpackage

// File: rtl/ascon_ctrl_blk_sched.sv
// Block scheduler: classifies the block at the current
// position and computes the next position without wrap.
module ascon_blk_sched
  import ascon_ctrl_pkg::*;
(
  input  logic [31:0] i_len,
  input  logic [31:0] i_pos,
  input  logic [4:0]  i_rate,
  output logic [31:0] o_nxt_pos,
  output logic        o_is_pad,
  output logic        o_is_last,
  output logic        o_phase_done
);

  logic [32:0] w_sum;

  // 33-bit sum so the end-of-data compare never wraps
  always_comb begin
    w_sum        = {1'b0, i_pos} + {28'd0, i_rate};
    o_nxt_pos    = w_sum[31:0];
    o_is_pad     = (i_pos >= i_len);
    o_is_last    = o_is_pad || (w_sum > {1'b0, i_len});
    o_phase_done = o_is_last;
  end

endmodule

// File: rtl/ascon_ctrl.sv
// ASCON core controller: sequences init, AD, payload,
// finalization and hash squeeze around an external core.
module ascon_ctrl
  import ascon_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_mode,
  input  logic [31:0]  cmd_ad_len,
  input  logic [31:0]  cmd_msg_len,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  output logic [1:0]   core_sel_type,
  output logic         core_mode_sel,
  output logic [31:0]  core_data_length,
  output logic [31:0]  core_data_position,
  output logic [127:0] core_data_in,
  output logic         core_en_init,
  output logic         core_en_ad_am,
  output logic         core_en_ed,
  output logic         core_en_hash,
  output logic         core_en_final,
  input  logic [127:0] core_data_out,
  input  logic [127:0] core_tag,
  input  logic         core_err,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         tag_valid,
  output logic [127:0] tag,
  output logic         busy,
  output logic         err
);

  state_t r_state;
  state_t w_nxt_state;

  logic [1:0]   r_mode;
  logic [31:0]  r_ad_len;
  logic [31:0]  r_msg_len;
  logic [31:0]  r_pos;
  logic [1:0]   r_cyc;
  logic [1:0]   r_slot;
  logic [127:0] r_data;
  logic         r_out_valid;
  logic [127:0] r_out_data;
  logic         r_out_last;
  logic         r_tag_valid;
  logic [127:0] r_tag;
  logic         r_err_pulse;
  logic         r_err_sticky;
  logic [1:0]   r_sel_type;
  logic         r_mode_sel;

  logic         w_hash;
  logic [4:0]   w_rate;
  logic [31:0]  w_len;
  logic         w_in_blk;
  logic         w_cyc_last;
  logic         w_first;
  logic         w_start;
  logic         w_blk_act;
  logic         w_blk_end;
  logic         w_accept;
  logic [127:0] w_blk_in;
  logic [31:0]  w_nxt_pos;
  logic         w_is_pad;
  logic         w_is_last;
  logic         w_phase_done;

  ascon_blk_sched u_sched (
    .i_len        (w_len),
    .i_pos        (r_pos),
    .i_rate       (w_rate),
    .o_nxt_pos    (w_nxt_pos),
    .o_is_pad     (w_is_pad),
    .o_is_last    (w_is_last),
    .o_phase_done (w_phase_done)
  );

  // Block handshake and datapath steering
  always_comb begin
    w_hash     = (r_mode == MODE_HASH);
    w_rate     = w_hash ? RATE_HASH : RATE_AEAD;
    w_len      = (r_state == S_AD) ? r_ad_len : r_msg_len;
    w_in_blk   = (r_state == S_AD) || (r_state == S_PAY);
    w_cyc_last = (r_cyc == LAST_CYC);
    w_first    = w_in_blk && (r_cyc == 2'd0);
    w_start    = w_first && (w_is_pad || blk_valid);
    w_blk_act  = w_start || (w_in_blk && r_cyc != 2'd0);
    w_blk_end  = w_in_blk && w_cyc_last;
    cmd_ready  = (r_state == S_IDLE);
    w_accept   = cmd_valid && cmd_ready;
    blk_ready  = w_first && !w_is_pad && blk_valid;
    if (w_is_pad)
      w_blk_in = '0;
    else if (w_hash)
      w_blk_in = {blk_data[127:64], 64'h0};
    else
      w_blk_in = blk_data;
    core_data_in = '0;
    if (w_in_blk && r_cyc != 2'd0)
      core_data_in = r_data;
    else if (w_start)
      core_data_in = w_blk_in;
    core_data_position = w_in_blk ? r_pos : '0;
    core_data_length   = w_in_blk ? w_len : '0;
    busy          = (r_state != S_IDLE);
    err           = r_err_pulse | r_err_sticky;
    out_valid     = r_out_valid;
    out_data      = r_out_data;
    out_last      = r_out_last;
    tag_valid     = r_tag_valid;
    tag           = r_tag;
    core_sel_type = r_sel_type;
    core_mode_sel = r_mode_sel;
  end

  // Next-state logic and core enables
  always_comb begin
    w_nxt_state   = r_state;
    core_en_init  = 1'b0;
    core_en_ad_am = 1'b0;
    core_en_ed    = 1'b0;
    core_en_hash  = 1'b0;
    core_en_final = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && cmd_mode != MODE_RSVD)
          w_nxt_state = S_INIT;
      end
      S_INIT: begin
        core_en_init = 1'b1;
        w_nxt_state  = w_hash ? S_PAY : S_AD;
      end
      S_AD: begin
        core_en_ad_am = w_blk_act;
        if (w_blk_end && w_phase_done)
          w_nxt_state = S_PAY;
      end
      S_PAY: begin
        if (w_hash)
          core_en_ad_am = w_blk_act;
        else
          core_en_ed = w_blk_act;
        if (w_blk_end && w_phase_done)
          w_nxt_state = w_hash ? S_SQZ : S_FINAL;
      end
      S_FINAL: begin
        core_en_final = 1'b1;
        if (w_cyc_last)
          w_nxt_state = S_DONE;
      end
      S_SQZ: begin
        core_en_hash = 1'b1;
        if (w_cyc_last && r_slot == LAST_SLOT)
          w_nxt_state = S_DONE;
      end
      S_DONE: w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt_state;
  end

  // Command latch, counters, result capture and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= '0;
      r_ad_len     <= '0;
      r_msg_len    <= '0;
      r_pos        <= '0;
      r_cyc        <= '0;
      r_slot       <= '0;
      r_data       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_tag_valid  <= 1'b0;
      r_tag        <= '0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_sel_type   <= '0;
      r_mode_sel   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_tag_valid <= 1'b0;
      r_err_pulse <= 1'b0;
      if (core_err)
        r_err_sticky <= 1'b1;
      else if (w_accept)
        r_err_sticky <= 1'b0;
      if (w_accept) begin
        r_mode      <= cmd_mode;
        r_ad_len    <= cmd_ad_len;
        r_msg_len   <= cmd_msg_len;
        r_pos       <= '0;
        r_cyc       <= '0;
        r_slot      <= '0;
        r_err_pulse <= (cmd_mode == MODE_RSVD);
        r_sel_type  <= (cmd_mode == MODE_HASH) ? 2'd1 : 2'd0;
        r_mode_sel  <= (cmd_mode == MODE_DEC);
      end
      if (w_in_blk) begin
        if (w_blk_end) begin
          r_cyc <= '0;
          r_pos <= w_is_last ? '0 : w_nxt_pos;
          if (r_state == S_PAY && !w_hash) begin
            r_out_valid <= 1'b1;
            r_out_data  <= core_data_out;
            r_out_last  <= w_is_last;
          end
        end else if (w_blk_act) begin
          r_cyc <= r_cyc + 2'd1;
          if (w_start)
            r_data <= w_blk_in;
        end
      end
      if (r_state == S_FINAL) begin
        if (w_cyc_last) begin
          r_cyc       <= '0;
          r_tag_valid <= 1'b1;
          r_tag       <= core_tag;
        end else begin
          r_cyc <= r_cyc + 2'd1;
        end
      end
      if (r_state == S_SQZ) begin
        if (w_cyc_last) begin
          r_cyc       <= '0;
          r_slot      <= r_slot + 2'd1;
          r_out_valid <= 1'b1;
          r_out_data  <= core_data_out;
          r_out_last  <= (r_slot == LAST_SLOT);
        end else begin
          r_cyc <= r_cyc + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ascon_ctrl.sv
// Testbench for ascon_ctrl: transaction-level reference
// model predicts every cycle of each command.
module tb_ascon_ctrl;

  localparam int MAXC = 400;
  localparam logic [4:0] EN_INIT = 5'b00001;
  localparam logic [4:0] EN_AD   = 5'b00010;
  localparam logic [4:0] EN_ED   = 5'b00100;
  localparam logic [4:0] EN_HASH = 5'b01000;
  localparam logic [4:0] EN_FIN  = 5'b10000;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_mode;
  logic [31:0]  cmd_ad_len;
  logic [31:0]  cmd_msg_len;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic [1:0]   core_sel_type;
  logic         core_mode_sel;
  logic [31:0]  core_data_length;
  logic [31:0]  core_data_position;
  logic [127:0] core_data_in;
  logic         core_en_init;
  logic         core_en_ad_am;
  logic         core_en_ed;
  logic         core_en_hash;
  logic         core_en_final;
  logic [127:0] core_data_out;
  logic [127:0] core_tag;
  logic         core_err;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_last;
  logic         tag_valid;
  logic [127:0] tag;
  logic         busy;
  logic         err;
  logic [4:0]   en_vec;

  always #5 clk = ~clk;

  ascon_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_mode           (cmd_mode),
    .cmd_ad_len         (cmd_ad_len),
    .cmd_msg_len        (cmd_msg_len),
    .blk_valid          (blk_valid),
    .blk_ready          (blk_ready),
    .blk_data           (blk_data),
    .core_sel_type      (core_sel_type),
    .core_mode_sel      (core_mode_sel),
    .core_data_length   (core_data_length),
    .core_data_position (core_data_position),
    .core_data_in       (core_data_in),
    .core_en_init       (core_en_init),
    .core_en_ad_am      (core_en_ad_am),
    .core_en_ed         (core_en_ed),
    .core_en_hash       (core_en_hash),
    .core_en_final      (core_en_final),
    .core_data_out      (core_data_out),
    .core_tag           (core_tag),
    .core_err           (core_err),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .out_last           (out_last),
    .tag_valid          (tag_valid),
    .tag                (tag),
    .busy               (busy),
    .err                (err)
  );

  assign en_vec = {core_en_final, core_en_hash, core_en_ed,
                   core_en_ad_am, core_en_init};

  int   total = 0;
  int   bad   = 0;
  logic sticky_exp = 1'b0;

  bit           vld [MAXC];
  logic [127:0] dat [MAXC];
  logic [127:0] cdo [MAXC];
  logic [127:0] tg  [MAXC];

  logic [4:0]   e_en   [MAXC];
  bit           e_rdy  [MAXC];
  bit           e_blk  [MAXC];
  bit           e_dchk [MAXC];
  bit           e_ov   [MAXC];
  bit           e_ol   [MAXC];
  bit           e_tv   [MAXC];
  logic [31:0]  e_pos  [MAXC];
  logic [31:0]  e_len  [MAXC];
  logic [127:0] e_din  [MAXC];
  logic [127:0] e_od   [MAXC];
  logic [127:0] e_tag  [MAXC];
  int           e_end;
  int           fin_t;

  task automatic chk(input string t, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", t, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic gen(input int pct);
    for (int c = 0; c < MAXC; c++) begin
      vld[c] = (c >= MAXC / 2) || (int'($urandom_range(99)) < pct);
      dat[c] = rnd128();
      cdo[c] = rnd128();
      tg[c]  = rnd128();
    end
  endtask

  task automatic do_phase(inout int t, input int len, input int r,
                          input logic [4:0] en, input bit outp,
                          input bit hsh);
    int nreal;
    int nb;
    bit pad;
    logic [127:0] d;
    nreal = (len + r - 1) / r;
    nb = nreal + ((len % r == 0) ? 1 : 0);
    for (int b = 0; b < nb; b++) begin
      pad = (b == nreal);
      if (!pad) begin
        while (!vld[t]) begin
          e_blk[t] = 1'b1;
          e_pos[t] = 32'(b * r);
          e_len[t] = 32'(len);
          t++;
        end
      end
      d = pad ? '0 : dat[t];
      if (hsh) d[63:0] = '0;
      e_rdy[t] = !pad;
      for (int k = 0; k < 2; k++) begin
        e_en[t+k]   = en;
        e_blk[t+k]  = 1'b1;
        e_pos[t+k]  = 32'(b * r);
        e_len[t+k]  = 32'(len);
        e_dchk[t+k] = 1'b1;
        e_din[t+k]  = d;
      end
      if (outp) begin
        e_ov[t+2] = 1'b1;
        e_od[t+2] = cdo[t+1];
        e_ol[t+2] = (b == nb - 1);
      end
      t += 2;
    end
  endtask

  task automatic build(input logic [1:0] m, input int ad,
                       input int ml);
    int t;
    for (int c = 0; c < MAXC; c++) begin
      e_en[c] = '0; e_rdy[c] = 0; e_blk[c] = 0; e_dchk[c] = 0;
      e_ov[c] = 0; e_ol[c] = 0; e_tv[c] = 0;
      e_pos[c] = '0; e_len[c] = '0; e_din[c] = '0;
      e_od[c] = '0; e_tag[c] = '0;
    end
    e_en[1] = EN_INIT;
    t = 2;
    if (m != 2'd2) begin
      do_phase(t, ad, 16, EN_AD, 1'b0, 1'b0);
      do_phase(t, ml, 16, EN_ED, 1'b1, 1'b0);
      fin_t = t;
      e_en[t] = EN_FIN;
      e_en[t+1] = EN_FIN;
      e_tv[t+2] = 1'b1;
      e_tag[t+2] = tg[t+1];
      e_end = t + 3;
    end else begin
      do_phase(t, ml, 8, EN_AD, 1'b0, 1'b1);
      for (int s = 0; s < 4; s++) begin
        e_en[t] = EN_HASH;
        e_en[t+1] = EN_HASH;
        e_ov[t+2] = 1'b1;
        e_od[t+2] = cdo[t+1];
        e_ol[t+2] = (s == 3);
        t += 2;
      end
      fin_t = -1;
      e_end = t + 1;
    end
  endtask

  task automatic run(input logic [1:0] m, input int ad, input int ml,
                     input bit noise, input int err_c, input bit do_rst,
                     output int tag_c, output int ov_n);
    logic eb;
    logic ee;
    build(m, ad, ml);
    tag_c = -1;
    ov_n = 0;
    for (int c = 0; c <= e_end + 1; c++) begin
      cmd_valid = (c == 0) || (noise && c > 0 && c < e_end && c % 3 == 0);
      cmd_mode = (c == 0) ? m : 2'd3;
      cmd_ad_len = (c == 0) ? 32'(ad) : $urandom();
      cmd_msg_len = (c == 0) ? 32'(ml) : $urandom();
      blk_valid = vld[c];
      blk_data = dat[c];
      core_data_out = cdo[c];
      core_tag = tg[c];
      core_err = (c == err_c);
      rst = do_rst && (c == fin_t);
      @(negedge clk);
      if (tag_valid) tag_c = c;
      if (out_valid) ov_n++;
      if (c == 0) begin
        chk("cmd_ready0", 128'(cmd_ready), 128'(1'b1));
        chk("busy0", 128'(busy), 128'(1'b0));
        chk("err0", 128'(err), 128'(sticky_exp));
      end else if (do_rst && c > fin_t) begin
        chk("rst_ready", 128'(cmd_ready), 128'(1'b1));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_en", 128'(en_vec), 128'(5'd0));
        chk("rst_tv", 128'(tag_valid), 128'(1'b0));
        chk("rst_ov", 128'(out_valid), 128'(1'b0));
        if (c >= fin_t + 3) begin
          @(posedge clk); #1;
          break;
        end
      end else begin
        eb = (c < e_end);
        ee = (err_c >= 0 && c > err_c);
        chk("busy", 128'(busy), 128'(eb));
        chk("cmd_ready", 128'(cmd_ready), 128'(!eb));
        chk("en", 128'(en_vec), 128'(e_en[c]));
        chk("blk_ready", 128'(blk_ready), 128'(e_rdy[c]));
        chk("err", 128'(err), 128'(ee));
        if (e_blk[c]) begin
          chk("pos", 128'(core_data_position), 128'(e_pos[c]));
          chk("len", 128'(core_data_length), 128'(e_len[c]));
        end
        if (e_dchk[c]) chk("din", core_data_in, e_din[c]);
        chk("out_valid", 128'(out_valid), 128'(e_ov[c]));
        if (e_ov[c]) begin
          chk("out_data", out_data, e_od[c]);
          chk("out_last", 128'(out_last), 128'(e_ol[c]));
        end
        chk("tag_valid", 128'(tag_valid), 128'(e_tv[c]));
        if (e_tv[c]) chk("tag", tag, e_tag[c]);
        if (c == 1) begin
          chk("sel_type", 128'(core_sel_type),
              128'((m == 2'd2) ? 2'd1 : 2'd0));
          chk("mode_sel", 128'(core_mode_sel), 128'(m == 2'd1));
        end
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    blk_valid = 1'b0;
    core_err = 1'b0;
    rst = 1'b0;
    sticky_exp = do_rst ? 1'b0 : (err_c >= 0);
  endtask

  task automatic bad_cmd();
    cmd_valid = 1'b1;
    cmd_mode = 2'd3;
    @(negedge clk);
    chk("m3_ready", 128'(cmd_ready), 128'(1'b1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("m3_err", 128'(err), 128'(1'b1));
    chk("m3_busy", 128'(busy), 128'(1'b0));
    chk("m3_ready1", 128'(cmd_ready), 128'(1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("m3_err_off", 128'(err), 128'(1'b0));
    chk("m3_busy1", 128'(busy), 128'(1'b0));
    @(posedge clk); #1;
    sticky_exp = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tc;
    int on;
    logic [1:0] m;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode = '0;
    cmd_ad_len = '0;
    cmd_msg_len = '0;
    blk_valid = 1'b0;
    blk_data = '0;
    core_data_out = '0;
    core_tag = '0;
    core_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_en", 128'(en_vec), 128'(5'd0));
    chk("rst_blk_ready", 128'(blk_ready), 128'(1'b0));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_tag_valid", 128'(tag_valid), 128'(1'b0));
    chk("rst_tag", tag, 128'd0);
    chk("rst_err", 128'(err), 128'(1'b0));
    chk("rst_din", core_data_in, 128'd0);
    chk("rst_pos", 128'(core_data_position), 128'd0);
    chk("rst_len", 128'(core_data_length), 128'd0);
    chk("rst_sel", 128'({core_sel_type, core_mode_sel}), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    gen(100);
    run(2'd0, 16, 16, 1'b0, -1, 1'b0, tc, on);
    chk("enc_tag_cycle", 128'(tc), 128'(12));
    chk("enc_out_count", 128'(on), 128'(2));

    gen(100);
    run(2'd1, 0, 5, 1'b0, -1, 1'b0, tc, on);
    chk("dec_tag_cycle", 128'(tc), 128'(8));
    chk("dec_out_count", 128'(on), 128'(1));

    gen(100);
    run(2'd2, 0, 8, 1'b0, -1, 1'b0, tc, on);
    chk("hash_out_count", 128'(on), 128'(4));
    chk("hash_no_tag", 128'(tc), 128'(-1));

    gen(100);
    for (int c = 4; c <= 8; c++) vld[c] = 1'b0;
    run(2'd0, 32, 16, 1'b0, -1, 1'b0, tc, on);
    chk("stall_tag_cycle", 128'(tc), 128'(19));

    gen(100);
    run(2'd0, 0, 0, 1'b0, -1, 1'b1, tc, on);
    chk("rst_final_no_tag", 128'(tc), 128'(-1));
    gen(70);
    run(2'd0, 16, 0, 1'b0, -1, 1'b0, tc, on);
    chk("after_rst_tag", 128'(tc >= 0), 128'(1'b1));

    bad_cmd();

    gen(80);
    run(2'd1, 20, 33, 1'b1, -1, 1'b0, tc, on);

    gen(90);
    run(2'd0, 8, 8, 1'b0, 3, 1'b0, tc, on);
    gen(90);
    run(2'd2, 0, 13, 1'b0, -1, 1'b0, tc, on);

    for (int i = 0; i < 14; i++) begin
      m = 2'($urandom_range(2));
      gen(int'($urandom_range(100, 40)));
      run(m, int'($urandom_range(40)), int'($urandom_range(40)),
          1'($urandom_range(1)), -1, 1'b0, tc, on);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_ctrl.md
ASCON_CTRL -- requirements
Module: ascon_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-002 The command port SHALL be:
- cmd_valid in 1
- cmd_ready out 1
- cmd_mode in 2: 0 = AEAD encrypt, 1 = AEAD decrypt, 2 = hash, 3 = reserved
- cmd_ad_len in 32: associated-data byte count
- cmd_msg_len in 32: plaintext, ciphertext or message byte count
REQ-003 The input block stream SHALL be: blk_valid in 1, blk_ready out 1, blk_data in 128 (hash: only bits [127:64] are meaningful).
REQ-004 The core-facing outputs SHALL be:
- core_sel_type out 2, core_mode_sel out 1
- core_data_length out 32, core_data_position out 32, core_data_in out 128
- core_en_init, core_en_ad_am, core_en_ed, core_en_hash, core_en_final: out 1 each
REQ-005 The core-facing inputs SHALL be: core_data_out in 128, core_tag in 128, core_err in 1.
REQ-006 The result port SHALL be:
- out_valid out 1, out_data out 128, out_last out 1
- tag_valid out 1, tag out 128
- busy out 1, err out 1

Function
REQ-007 The FSM SHALL have states IDLE, INIT, AD, PAY, FINAL, SQZ, DONE.
REQ-008 In IDLE cmd_ready SHALL be 1; a command SHALL be accepted on cmd_valid&cmd_ready, latching mode and both lengths.
REQ-009 Core control on accept: core_sel_type = 1 for hash and 0 otherwise; core_mode_sel = 1 only for decrypt.
REQ-010 An accepted mode 3 SHALL pulse err for 1 cycle and remain in IDLE.
REQ-011 INIT SHALL last exactly 1 cycle with core_en_init = 1, then go to AD for AEAD modes and to PAY for hash.
REQ-012 Rate R SHALL be 16 bytes for AEAD and 8 bytes for hash.
REQ-013 Each phase SHALL process blocks at positions 0, R, 2R, ... while position < len, then one zero pad block at position len if len mod R == 0 (this includes len = 0).
REQ-014 Each block SHALL occupy exactly 2 cycles, with its enable (core_en_ad_am in AD; core_en_ed in PAY for AEAD; core_en_ad_am in PAY for hash) and core_data_in/core_data_position/core_data_length held stable.
REQ-015 A real block SHALL start only on blk_valid&blk_ready; blk_ready SHALL be a 1-cycle pulse at block start.
REQ-016 While blk_valid = 0 the FSM SHALL stall with all core enables 0.
REQ-017 Pad blocks SHALL not consume input; core_data_in = 0 and blk_ready = 0.
REQ-018 In hash mode core_data_in SHALL be {blk_data[127:64], 64'h0}.
REQ-019 In AEAD PAY, one cycle after each block's second cycle, out_valid SHALL pulse with out_data = captured core_data_out, including for the pad block. out_last SHALL mark the pad block or the final partial block.
REQ-020 There is no output backpressure; consumers SHALL accept every out_valid pulse.
REQ-021 FINAL SHALL hold core_en_final = 1 for 2 cycles, then pulse tag_valid for 1 cycle with tag = core_tag, then go to DONE.
REQ-022 Hash: after PAY, SQZ SHALL run 4 slots of 2 cycles each with core_en_hash = 1. After each slot, out_valid SHALL pulse with out_data = core_data_out; out_last SHALL be set on slot 3.
REQ-023 DONE SHALL last 1 cycle and then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 At most one core enable SHALL be 1 in any cycle.
REQ-026 cmd_valid while busy SHALL be ignored (cmd_ready = 0).
REQ-027 The position counter SHALL be 32-bit unsigned and compared with "<". len = 32'hFFFF_FFF0 SHALL not wrap the counter before termination; this is achieved by a 33-bit internal sum.
REQ-028 core_err = 1 in any cycle SHALL set err sticky until the next accepted command.

Reset
REQ-029 When rst = 1 at a clock edge, the FSM SHALL go to IDLE and:
- cmd_ready = 1
- all other outputs = 0, including all core enables, out_data, tag and counters
REQ-030 Reset mid-operation SHALL abandon the operation with no out_valid or tag_valid pulse afterwards.

Structure
REQ-031 A package ascon_ctrl_pkg SHALL hold:
- the state enum
- cmd_mode encodings
- the rate constants RATE_AEAD = 16 and RATE_HASH = 8
- SQZ_SLOTS = 4
- BLK_CYCLES = 2
REQ-032 One sub-module ascon_blk_sched SHALL compute, from len, position and rate: next position, is_pad, is_last and phase_done.

Verification
REQ-033 Encrypt, ad_len = 16, msg_len = 16, blk_valid always 1 -> blocks: AD real + AD pad + PAY real + PAY pad. 2 out_valid pulses; tag_valid at cycle 12 after accept (1 + 4 + 4 + 2 + 1).
REQ-034 Decrypt, ad_len = 0, msg_len = 5 -> 1 AD pad block at position 0, 1 PAY block, 1 out_valid with out_last = 1, tag_valid once.
REQ-035 Hash, msg_len = 8 -> PAY blocks at positions 0 and 8 (pad), core_data_in[63:0] = 0, then 4 SQZ slots and 4 out_valid pulses, the last with out_last.
REQ-036 blk_valid low for 5 cycles mid-AD -> all core enables 0 during the stall, positions unchanged, final tag timing delayed by exactly 5 cycles.
REQ-037 rst pulsed during FINAL -> IDLE next cycle, tag_valid never asserted; a following command completes normally.
REQ-038 Mode 3 command -> 1-cycle err pulse, busy stays 0; cmd_valid asserted while busy -> ignored.
